// File: rtl/mul_accum_pkg.sv
// Shared types and default widths for the multiplier-downstream accumulator.
// The default accumulator holds 8 x 255*255 without wrapping.
package mul_accum_pkg;

    typedef enum logic {ACCUM, HOLD} mul_accum_state_t;

    localparam int DEF_PROD_W    = 16;
    localparam int DEF_ACC_W     = 20;
    localparam int DEF_BURST_LEN = 8;

endpackage

// File: rtl/mul_accumulate.sv
// Burst accumulator for unsigned products with a valid/ready result port.
// First register stage after the combinational multiplier.
module mul_accumulate
    import mul_accum_pkg::*;
#(
    parameter int PROD_W    = DEF_PROD_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    mul_accum_state_t state;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             rdy;
    logic             vld;

    logic             accept;
    logic             first;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] sum;
    logic             carry;
    logic [CNT_W-1:0] cnt_nxt;
    logic             done;

    assign in_ready = rdy & ~rst;
    assign accept   = in_valid & in_ready;

    // acc/ovf from the previous burst are cleared on its first beat
    assign first   = (cnt == '0);
    assign base    = first ? '0 : acc;
    assign {carry, sum} = {1'b0, base} + (ACC_W + 1)'(in_prod);
    assign cnt_nxt = cnt + 1'b1;
    assign done    = in_last | (cnt_nxt == CNT_W'(BURST_LEN));

    assign out_valid    = vld;
    assign out_sum      = acc;
    assign out_count    = cnt;
    assign out_overflow = ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            rdy   <= 1'b1;
            vld   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc <= sum;
                        cnt <= cnt_nxt;
                        ovf <= (first ? 1'b0 : ovf) | carry;
                        if (done) begin
                            state <= HOLD;
                            rdy   <= 1'b0;
                            vld   <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= ACCUM;
                        cnt   <= '0;
                        rdy   <= 1'b1;
                        vld   <= 1'b0;
                    end
                end
                default: begin
                    state <= ACCUM;
                    rdy   <= 1'b1;
                    vld   <= 1'b0;
                end
            endcase
        end
    end

endmodule
